// File: rtl/booth_mult_arbiter_pkg.sv
// booth_mult_arbiter_pkg: shared FSM encodings and default sizes for the booth multiplier arbiter
package booth_mult_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ = 4;
endpackage

// File: rtl/booth_step_core.sv
// booth_step_core: radix-2 booth datapath; ports clk, rst, load (latch mc/mp), step_en (one booth step), last_step (counter at final step), prod (low 2*WIDTH bits of {A,Q})
module booth_step_core
  import booth_mult_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   mc,
  input  logic [WIDTH-1:0]   mp,
  input  logic               step_en,
  output logic               last_step,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH:0]   a, m, sum;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CW-1:0]    cnt;
  always_comb sum = ({q[0], q_1} == 2'b01) ? a + m : ({q[0], q_1} == 2'b10) ? a - m : a;
  always_ff @(posedge clk) begin
    if (rst) begin
      a   <= '0;
      m   <= '0;
      q   <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      a   <= '0;
      m   <= {mc[WIDTH-1], mc};
      q   <= mp;
      q_1 <= 1'b0;
      cnt <= '0;
    end else if (step_en) begin
      a   <= {sum[WIDTH], sum[WIDTH:1]};
      q   <= {sum[0], q[WIDTH-1:1]};
      q_1 <= q[0];
      cnt <= cnt + 1'b1;
    end
  end
  assign last_step = cnt == CW'(WIDTH - 1);
  assign prod = {a[WIDTH-1:0], q};
endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin sharing of one booth multiplier; ports req_valid/req_ready/req_mc/req_mp (per requester), rsp_valid/rsp_ready/rsp_id/rsp_prod (tagged product), busy
module booth_mult_arbiter
  import booth_mult_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_mc,
  input  logic [NREQ*WIDTH-1:0] req_mp,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [2*WIDTH-1:0]    rsp_prod,
  output logic                  busy
);
  state_t            state, nxt;
  logic [ID_W-1:0]   rr_ptr, win, id_q;
  logic              hs, last_step;
  logic [2*WIDTH-1:0] prod;
  // descending scan so the requester nearest rr_ptr is written last and wins
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) win = ID_W'((int'(rr_ptr) + k) % NREQ);
  end
  assign hs = state == ST_IDLE && |req_valid;
  assign req_ready = hs ? NREQ'(1) << win : '0;
  always_comb begin
    nxt = state;
    nxt = state == ST_IDLE ? (hs ? ST_RUN : ST_IDLE) :
          state == ST_RUN  ? (last_step ? ST_DONE : ST_RUN) :
          state == ST_DONE ? (rsp_ready ? ST_IDLE : ST_DONE) : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
    end else begin
      state <= nxt;
      if (hs) begin
        rr_ptr <= win == ID_W'(NREQ - 1) ? '0 : win + 1'b1;
        id_q   <= win;
      end
    end
  end
  booth_step_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (hs),
    .mc       (req_mc[win*WIDTH +: WIDTH]),
    .mp       (req_mp[win*WIDTH +: WIDTH]),
    .step_en  (state == ST_RUN),
    .last_step(last_step),
    .prod     (prod)
  );
  assign rsp_valid = state == ST_DONE;
  assign busy = state != ST_IDLE;
  assign rsp_id = id_q;
  assign rsp_prod = rsp_valid ? prod : '0;
endmodule
